// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - Execute stage: single-cycle ALU, 32-step shift-add multiplier, branch resolve.
module ex_stage (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        Valid_In,
    input  logic        Flush_In,
    input  logic        RegWriteEN_In,
    input  logic        Mem2RegSEL_In,
    input  logic        MemWriteEN_In,
    input  logic        Branch_In,
    input  logic        ALUSrc_In,
    input  logic        RegDstSEL_In,
    input  logic [3:0]  ALUCtrl_In,
    input  logic [31:0] RegData1_In,
    input  logic [31:0] RegData2_In,
    input  logic [31:0] Imm_In,
    input  logic [31:0] PC_In,
    input  logic [4:0]  RTAddr_In,
    input  logic [4:0]  RDAddr_In,
    output logic        Stall_Out,
    output logic        Valid_Out,
    output logic        RegWriteEN_Out,
    output logic        Mem2RegSEL_Out,
    output logic        MemWriteEN_Out,
    output logic [31:0] ALUResult_Out,
    output logic [31:0] StoreData_Out,
    output logic [4:0]  WriteAddr_Out,
    output logic        BranchTaken_Out,
    output logic [31:0] BranchTarget_Out
);
    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [31:0] op_a, op_b, alu_result, branch_target, mul_step;
    logic [4:0]  write_addr;
    logic        is_mul, branch_taken;

    logic [31:0] mul_a, mul_b, mul_prod, mul_store, mul_target;
    logic [4:0]  mul_waddr;
    logic        mul_regwrite, mul_mem2reg, mul_memwrite, mul_taken;

    assign op_a          = RegData1_In;
    assign op_b          = ALUSrc_In ? Imm_In : RegData2_In;
    assign is_mul        = (ALUCtrl_In == 4'd10);
    assign write_addr    = RegDstSEL_In ? RDAddr_In : RTAddr_In;
    assign branch_taken  = Branch_In && (RegData1_In == RegData2_In);
    assign branch_target = PC_In + 32'd4 + (Imm_In << 2);
    // Bit cnt of the multiplier selects whether the shifted multiplicand is added this step.
    assign mul_step      = mul_prod + (mul_b[cnt] ? (mul_a << cnt) : 32'd0);

    always_comb begin
        alu_result = 32'd0;
        case (ALUCtrl_In)
            4'd0: alu_result = op_a + op_b;
            4'd1: alu_result = op_a - op_b;
            4'd2: alu_result = op_a & op_b;
            4'd3: alu_result = op_a | op_b;
            4'd4: alu_result = op_a ^ op_b;
            4'd5: alu_result = ~(op_a | op_b);
            4'd6: alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd7: alu_result = op_a << op_b[4:0];
            4'd8: alu_result = op_a >> op_b[4:0];
            4'd9: alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            default: alu_result = 32'd0;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        Stall_Out  = 1'b0;
        if (Flush_In) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    Stall_Out = Valid_In && is_mul;
                    if (Valid_In && is_mul) state_next = MUL_BUSY;
                end
                MUL_BUSY: begin
                    Stall_Out = (cnt != 5'd31);
                    if (cnt == 5'd31) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
        // Upstream must not see a stall while the stage is being reset.
        if (RESET) Stall_Out = 1'b0;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            Valid_Out        <= 1'b0;
            RegWriteEN_Out   <= 1'b0;
            Mem2RegSEL_Out   <= 1'b0;
            MemWriteEN_Out   <= 1'b0;
            ALUResult_Out    <= 32'd0;
            StoreData_Out    <= 32'd0;
            WriteAddr_Out    <= 5'd0;
            BranchTaken_Out  <= 1'b0;
            BranchTarget_Out <= 32'd0;
            cnt              <= 5'd0;
            mul_a            <= 32'd0;
            mul_b            <= 32'd0;
            mul_prod         <= 32'd0;
            mul_store        <= 32'd0;
            mul_target       <= 32'd0;
            mul_waddr        <= 5'd0;
            mul_regwrite     <= 1'b0;
            mul_mem2reg      <= 1'b0;
            mul_memwrite     <= 1'b0;
            mul_taken        <= 1'b0;
        end else begin
            Valid_Out       <= 1'b0;
            RegWriteEN_Out  <= 1'b0;
            MemWriteEN_Out  <= 1'b0;
            BranchTaken_Out <= 1'b0;
            if (Flush_In) begin
                cnt <= 5'd0;
            end else if (state == IDLE) begin
                if (Valid_In && is_mul) begin
                    mul_a        <= op_a;
                    mul_b        <= op_b;
                    mul_prod     <= 32'd0;
                    mul_store    <= RegData2_In;
                    mul_target   <= branch_target;
                    mul_waddr    <= write_addr;
                    mul_regwrite <= RegWriteEN_In;
                    mul_mem2reg  <= Mem2RegSEL_In;
                    mul_memwrite <= MemWriteEN_In;
                    mul_taken    <= branch_taken;
                    cnt          <= 5'd0;
                end else if (Valid_In) begin
                    Valid_Out        <= 1'b1;
                    RegWriteEN_Out   <= RegWriteEN_In;
                    Mem2RegSEL_Out   <= Mem2RegSEL_In;
                    MemWriteEN_Out   <= MemWriteEN_In;
                    ALUResult_Out    <= alu_result;
                    StoreData_Out    <= RegData2_In;
                    WriteAddr_Out    <= write_addr;
                    BranchTaken_Out  <= branch_taken;
                    BranchTarget_Out <= branch_target;
                end
            end else begin
                mul_prod <= mul_step;
                if (cnt == 5'd31) begin
                    Valid_Out        <= 1'b1;
                    RegWriteEN_Out   <= mul_regwrite;
                    Mem2RegSEL_Out   <= mul_mem2reg;
                    MemWriteEN_Out   <= mul_memwrite;
                    ALUResult_Out    <= mul_step;
                    StoreData_Out    <= mul_store;
                    WriteAddr_Out    <= mul_waddr;
                    BranchTaken_Out  <= mul_taken;
                    BranchTarget_Out <= mul_target;
                    cnt              <= 5'd0;
                end else begin
                    cnt <= cnt + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - Vector table, directed multi-cycle sequences and a random run against a reference model.
module tb_ex_stage;
    logic        CLOCK = 1'b0;
    logic        RESET, Valid_In, Flush_In;
    logic        RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Branch_In, ALUSrc_In, RegDstSEL_In;
    logic [3:0]  ALUCtrl_In;
    logic [31:0] RegData1_In, RegData2_In, Imm_In, PC_In;
    logic [4:0]  RTAddr_In, RDAddr_In;
    logic        Stall_Out, Valid_Out, RegWriteEN_Out, Mem2RegSEL_Out, MemWriteEN_Out, BranchTaken_Out;
    logic [31:0] ALUResult_Out, StoreData_Out, BranchTarget_Out;
    logic [4:0]  WriteAddr_Out;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .CLOCK(CLOCK), .RESET(RESET), .Valid_In(Valid_In), .Flush_In(Flush_In),
        .RegWriteEN_In(RegWriteEN_In), .Mem2RegSEL_In(Mem2RegSEL_In), .MemWriteEN_In(MemWriteEN_In),
        .Branch_In(Branch_In), .ALUSrc_In(ALUSrc_In), .RegDstSEL_In(RegDstSEL_In), .ALUCtrl_In(ALUCtrl_In),
        .RegData1_In(RegData1_In), .RegData2_In(RegData2_In), .Imm_In(Imm_In), .PC_In(PC_In),
        .RTAddr_In(RTAddr_In), .RDAddr_In(RDAddr_In), .Stall_Out(Stall_Out), .Valid_Out(Valid_Out),
        .RegWriteEN_Out(RegWriteEN_Out), .Mem2RegSEL_Out(Mem2RegSEL_Out), .MemWriteEN_Out(MemWriteEN_Out),
        .ALUResult_Out(ALUResult_Out), .StoreData_Out(StoreData_Out), .WriteAddr_Out(WriteAddr_Out),
        .BranchTaken_Out(BranchTaken_Out), .BranchTarget_Out(BranchTarget_Out)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        src, rdsel;
        logic [4:0]  rt, rd;
        logic [31:0] res;
        logic [4:0]  wa;
    } vec_t;

    typedef struct {
        logic        full, valid, rw, m2r, mw, bt;
        logic [31:0] res, sd, tgt;
        logic [4:0]  wa;
    } exp_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_idle();
        Valid_In = 0; Flush_In = 0; RegWriteEN_In = 0; Mem2RegSEL_In = 0; MemWriteEN_In = 0;
        Branch_In = 0; ALUSrc_In = 0; RegDstSEL_In = 0; ALUCtrl_In = 0; RegData1_In = 0;
        RegData2_In = 0; Imm_In = 0; PC_In = 0; RTAddr_In = 0; RDAddr_In = 0;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic src, input logic rdsel,
                             input logic [4:0] rt, input logic [4:0] rd, input logic br,
                             input logic [31:0] pc);
        Valid_In = 1; Flush_In = 0; RegWriteEN_In = 1; Mem2RegSEL_In = 0; MemWriteEN_In = 0;
        Branch_In = br; ALUSrc_In = src; RegDstSEL_In = rdsel; ALUCtrl_In = op;
        RegData1_In = a; RegData2_In = b; Imm_In = imm; PC_In = pc; RTAddr_In = rt; RDAddr_In = rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, Valid_Out, 0);
        chk({tag, "_rw"}, RegWriteEN_Out, 0);
        chk({tag, "_m2r"}, Mem2RegSEL_Out, 0);
        chk({tag, "_mw"}, MemWriteEN_Out, 0);
        chk({tag, "_res"}, ALUResult_Out, 0);
        chk({tag, "_sd"}, StoreData_Out, 0);
        chk({tag, "_wa"}, WriteAddr_Out, 0);
        chk({tag, "_bt"}, BranchTaken_Out, 0);
        chk({tag, "_tgt"}, BranchTarget_Out, 0);
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            7: return a << sh;
            8: return a >> sh;
            9: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            10: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: remaining busy cycles of an in-flight multiply plus its finished record.
    int   busy_left = 0;
    exp_t pend, expv;

    function automatic exp_t accept_now();
        exp_t e;
        logic [31:0] b;
        b = ALUSrc_In ? Imm_In : RegData2_In;
        e.full = 1; e.valid = 1; e.rw = RegWriteEN_In; e.m2r = Mem2RegSEL_In; e.mw = MemWriteEN_In;
        e.bt = Branch_In && (RegData1_In == RegData2_In);
        e.res = ref_alu(ALUCtrl_In, RegData1_In, b);
        e.sd = RegData2_In;
        e.tgt = PC_In + 4 + Imm_In * 4;
        e.wa = RegDstSEL_In ? RDAddr_In : RTAddr_In;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    logic exp_stall;
    int   n, stalls, valids;

    initial begin
        vecs[0]  = '{4'd0,  32'd5,          32'd7,          32'd0,  1'b0, 1'b1, 5'd2, 5'd3,  32'd12,         5'd3};
        vecs[1]  = '{4'd1,  32'd5,          32'd7,          32'd0,  1'b0, 1'b0, 5'd2, 5'd3,  32'hFFFF_FFFE, 5'd2};
        vecs[2]  = '{4'd2,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,  1'b0, 1'b1, 5'd1, 5'd4,  32'h00F0_00F0, 5'd4};
        vecs[3]  = '{4'd3,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,  1'b0, 1'b1, 5'd1, 5'd5,  32'hFFF0_FFF0, 5'd5};
        vecs[4]  = '{4'd4,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,  1'b0, 1'b1, 5'd1, 5'd6,  32'hFF00_FF00, 5'd6};
        vecs[5]  = '{4'd5,  32'd0,          32'd0,          32'd0,  1'b0, 1'b1, 5'd1, 5'd7,  32'hFFFF_FFFF, 5'd7};
        vecs[6]  = '{4'd6,  32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0, 1'b1, 5'd1, 5'd8,  32'd1,         5'd8};
        vecs[7]  = '{4'd6,  32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0, 1'b1, 5'd1, 5'd8,  32'd0,         5'd8};
        vecs[8]  = '{4'd7,  32'd1,          32'd0,          32'd35, 1'b1, 1'b1, 5'd1, 5'd10, 32'd8,         5'd10};
        vecs[9]  = '{4'd8,  32'h8000_0000,  32'd4,          32'd0,  1'b0, 1'b1, 5'd1, 5'd11, 32'h0800_0000, 5'd11};
        vecs[10] = '{4'd9,  32'h8000_0000,  32'd0,          32'd4,  1'b1, 1'b0, 5'd9, 5'd12, 32'hF800_0000, 5'd9};
        vecs[11] = '{4'd11, 32'd5,          32'd7,          32'd0,  1'b0, 1'b1, 5'd1, 5'd13, 32'd0,         5'd13};
        vecs[12] = '{4'd15, 32'd5,          32'd7,          32'd0,  1'b0, 1'b1, 5'd1, 5'd14, 32'd0,         5'd14};

        // Reset with a multiply presented: no stall, everything zero.
        set_instr(4'd10, 32'd3, 32'd4, 32'd0, 0, 1, 0, 1, 0, 0);
        RESET = 1;
        #1 chk("reset_stall", Stall_Out, 0);
        tick(); tick();
        chk_all_zero("reset");
        RESET = 0;
        set_idle();
        tick();

        foreach (vecs[i]) begin
            set_instr(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src, vecs[i].rdsel,
                      vecs[i].rt, vecs[i].rd, 0, 0);
            #1 chk($sformatf("vec%0d_stall", i), Stall_Out, 0);
            tick();
            chk($sformatf("vec%0d_valid", i), Valid_Out, 1);
            chk($sformatf("vec%0d_res", i), ALUResult_Out, vecs[i].res);
            chk($sformatf("vec%0d_wa", i), WriteAddr_Out, vecs[i].wa);
        end
        set_idle();
        tick();
        chk("bubble_valid", Valid_Out, 0);

        // Multiply 0xFFFFFFFF * 3, then 6 * 7 accepted right after completion.
        set_instr(4'd10, 32'hFFFF_FFFF, 32'd3, 32'd0, 0, 1, 0, 17, 0, 0);
        n = 0; stalls = 0;
        while (!Valid_Out && n < 40) begin
            #1 if (Stall_Out) stalls++;
            tick(); n++;
            if (n == 5) set_instr(4'd0, 32'd1, 32'd1, 32'd0, 0, 1, 0, 30, 0, 0);
        end
        chk("mul1_latency", n, 33);
        chk("mul1_stalls", stalls, 32);
        chk("mul1_res", ALUResult_Out, 32'hFFFF_FFFD);
        chk("mul1_wa", WriteAddr_Out, 17);
        set_instr(4'd10, 32'd6, 32'd7, 32'd0, 0, 1, 0, 18, 0, 0);
        n = 0;
        while (n == 0 || (!Valid_Out && n < 40)) begin
            tick(); n++;
        end
        chk("mul2_latency", n, 33);
        chk("mul2_res", ALUResult_Out, 42);
        chk("mul2_wa", WriteAddr_Out, 18);

        // Branch equal, not equal, and equal with immediate operand selected.
        set_instr(4'd0, 32'd9, 32'd9, 32'd2, 0, 1, 0, 1, 1, 32'h100);
        tick();
        chk("br_taken", BranchTaken_Out, 1);
        chk("br_target", BranchTarget_Out, 32'h10C);
        set_idle();
        tick();
        chk("br_one_cycle", BranchTaken_Out, 0);
        set_instr(4'd0, 32'd9, 32'd8, 32'd2, 0, 1, 0, 1, 1, 32'h100);
        tick();
        chk("br_ne", BranchTaken_Out, 0);
        set_instr(4'd0, 32'd9, 32'd9, 32'd5, 1, 1, 0, 1, 1, 32'h200);
        tick();
        chk("br_alusrc", BranchTaken_Out, 1);
        chk("br_alusrc_tgt", BranchTarget_Out, 32'h218);

        // Flush a multiply at Cnt=10.
        set_instr(4'd10, 32'd6, 32'd7, 32'd0, 0, 1, 0, 20, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) tick();
        Flush_In = 1; Valid_In = 0;
        #1 chk("flush_stall_now", Stall_Out, 0);
        tick();
        set_idle();
        #1 chk("flush_stall_after", Stall_Out, 0);
        chk("flush_valid", Valid_Out, 0);
        valids = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (Valid_Out) valids++;
        end
        chk("flush_no_result", valids, 0);
        set_instr(4'd0, 32'd5, 32'd7, 32'd0, 0, 1, 0, 3, 0, 0);
        tick();
        chk("flush_add_res", ALUResult_Out, 12);
        chk("flush_add_valid", Valid_Out, 1);

        // Reset for one cycle in the middle of a multiply.
        set_instr(4'd10, 32'd6, 32'd7, 32'd0, 0, 1, 0, 21, 0, 0);
        tick();
        for (int k = 0; k < 5; k++) tick();
        RESET = 1;
        #1 chk("rst_mid_stall", Stall_Out, 0);
        tick();
        chk_all_zero("rst_mid");
        RESET = 0;
        set_instr(4'd0, 32'd5, 32'd7, 32'd0, 0, 1, 0, 3, 0, 0);
        #1 chk("rst_add_stall", Stall_Out, 0);
        tick();
        chk("rst_add_res", ALUResult_Out, 12);
        chk("rst_add_valid", Valid_Out, 1);
        chk("rst_add_wa", WriteAddr_Out, 3);

        // Random run against the model.
        set_idle();
        tick();
        busy_left = 0;
        for (int i = 0; i < 3000; i++) begin
            RESET         = ($urandom_range(0, 199) == 0);
            Flush_In      = ($urandom_range(0, 39) == 0);
            Valid_In      = ($urandom_range(0, 9) < 8);
            RegWriteEN_In = 1'($urandom);
            Mem2RegSEL_In = 1'($urandom);
            MemWriteEN_In = 1'($urandom);
            Branch_In     = 1'($urandom);
            ALUSrc_In     = 1'($urandom);
            RegDstSEL_In  = 1'($urandom);
            ALUCtrl_In    = ($urandom_range(0, 7) == 0) ? 4'd10 : 4'($urandom);
            RegData1_In   = $urandom;
            RegData2_In   = ($urandom_range(0, 3) == 0) ? RegData1_In : $urandom;
            Imm_In        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            PC_In         = $urandom;
            RTAddr_In     = 5'($urandom);
            RDAddr_In     = 5'($urandom);
            #1;
            exp_stall = !RESET && !Flush_In &&
                        ((busy_left == 0 && Valid_In && ALUCtrl_In == 4'd10) || busy_left > 1);
            chk("rnd_stall", Stall_Out, exp_stall);
            if (RESET) begin
                expv = bubble(); expv.full = 1; busy_left = 0;
            end else if (Flush_In) begin
                expv = bubble(); busy_left = 0;
            end else if (busy_left == 0) begin
                expv = bubble();
                if (Valid_In && ALUCtrl_In == 4'd10) begin
                    pend = accept_now(); busy_left = 32;
                end else if (Valid_In) begin
                    expv = accept_now();
                end
            end else begin
                busy_left--;
                expv = (busy_left == 0) ? pend : bubble();
            end
            tick();
            chk("rnd_valid", Valid_Out, expv.valid);
            chk("rnd_rw", RegWriteEN_Out, expv.rw);
            chk("rnd_mw", MemWriteEN_Out, expv.mw);
            chk("rnd_bt", BranchTaken_Out, expv.bt);
            if (expv.full) begin
                chk("rnd_m2r", Mem2RegSEL_Out, expv.m2r);
                chk("rnd_res", ALUResult_Out, expv.res);
                chk("rnd_sd", StoreData_Out, expv.sd);
                chk("rnd_wa", WriteAddr_Out, expv.wa);
                chk("rnd_tgt", BranchTarget_Out, expv.tgt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters: none; data width is fixed at 32 bits.
REQ-002 CLOCK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 Valid_In  input  1  ID/EX slot holds a real instruction.
REQ-005 Flush_In  input  1  kill the instruction currently in EX.
REQ-006 RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Branch_In, ALUSrc_In, RegDstSEL_In  input  1 each  ID/EX control fields.
REQ-007 ALUCtrl_In  input  4  operation code.
REQ-008 RegData1_In, RegData2_In, Imm_In, PC_In  input  32 each  operands, sign-extended immediate, instruction PC.
REQ-009 RTAddr_In, RDAddr_In  input  5 each  candidate destination addresses.
REQ-010 Stall_Out  output  1  combinational; high means ID/EX and earlier stages hold.
REQ-011 Valid_Out, RegWriteEN_Out, Mem2RegSEL_Out, MemWriteEN_Out  output  1 each  registered EX/MEM controls.
REQ-012 ALUResult_Out, StoreData_Out  output  32 each  registered result and store data.
REQ-013 WriteAddr_Out  output  5  registered destination register.
REQ-014 BranchTaken_Out  output  1  registered taken-branch pulse.
REQ-015 BranchTarget_Out  output  32  registered branch target address.

Function
REQ-016 Operand A SHALL be RegData1_In; operand B SHALL be Imm_In when ALUSrc_In=1, else RegData2_In.
REQ-017 ALUCtrl_In SHALL decode as follows: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 1/0), 7 SLL, 8 SRL, 9 SRA (shift A by B[4:0]), 10 MUL (low 32 bits), 11-15 result 0.
REQ-018 All arithmetic SHALL be modulo 2^32 with no overflow flag.
REQ-019 WriteAddr SHALL be RDAddr_In when RegDstSEL_In=1, else RTAddr_In.
REQ-020 StoreData SHALL be RegData2_In.
REQ-021 FSM states SHALL be IDLE and MUL_BUSY, with a 5-bit iteration counter Cnt.
REQ-022 IDLE with Valid_In=1 and op != MUL: all outputs SHALL be registered at the next edge (1-cycle latency), with Valid_Out=1 for that cycle.
REQ-023 IDLE with Valid_In=0: the next edge SHALL register a bubble (Valid_Out, RegWriteEN_Out, MemWriteEN_Out, BranchTaken_Out = 0).
REQ-024 IDLE with Valid_In=1 and op=MUL: the edge SHALL latch A, B and the controls, clear the product, set Cnt=0, enter MUL_BUSY and register a bubble.
REQ-025 MUL_BUSY SHALL perform one shift-add step per cycle, with inputs ignored.
REQ-026 MUL_BUSY at Cnt=31: the step SHALL complete, the result and latched controls SHALL register with Valid_Out=1, and the FSM SHALL return to IDLE.
REQ-027 MUL_BUSY at Cnt<31: Cnt SHALL increment and a bubble SHALL be registered.
REQ-028 Stall_Out SHALL equal (IDLE & Valid_In & op=MUL & !Flush_In) | (MUL_BUSY & Cnt!=31 & !Flush_In).
REQ-029 MUL occupancy SHALL be 33 cycles from first presentation to result.
REQ-030 Back-to-back MUL SHALL be accepted in the IDLE cycle following completion.
REQ-031 Branch: BranchTaken_Out SHALL be 1 when Valid_In & Branch_In & RegData1_In==RegData2_In, independent of ALUSrc.
REQ-032 BranchTarget_Out SHALL be PC_In + 4 + (Imm_In<<2), registered every accepted cycle.
REQ-033 BranchTaken_Out SHALL be high for exactly one cycle.
REQ-034 Flush_In SHALL override everything: the next edge registers a bubble, forces IDLE and clears Cnt; a MUL in progress is discarded with no result.
REQ-035 Flush_In and a new Valid_In in the same cycle SHALL result in the instruction being dropped.

Reset
REQ-036 While RESET=1, the following edge SHALL drive all registered outputs to 0, state IDLE, Cnt=0; Stall_Out SHALL be 0.
REQ-037 RESET SHALL take priority over Flush_In and the FSM, including mid-MUL (result discarded).

Verification
REQ-038 ADD: A=5, B=7, ALUSrc=0, RegDstSEL=1, RD=3 -> next cycle ALUResult=12, WriteAddr=3, Valid_Out=1, Stall_Out=0 throughout.
REQ-039 SRA immediate: A=0x80000000, Imm=4, ALUSrc=1 -> ALUResult=0xF8000000, WriteAddr=RTAddr.
REQ-040 MUL: A=0xFFFFFFFF, B=3 -> Stall_Out high 32 cycles, result 0xFFFFFFFD valid 33 cycles after presentation; second MUL 6x7 immediately after -> 42.
REQ-041 Branch: PC=0x100, A=B=9, Imm=2, Branch=1 -> BranchTaken=1 for one cycle, BranchTarget=0x10C; A!=B -> BranchTaken=0.
REQ-042 Flush at Cnt=10 of a MUL -> next cycle IDLE, Stall_Out=0, Valid_Out=0, and no result ever appears.
REQ-043 RESET asserted mid-MUL for one cycle -> all outputs 0, Stall_Out=0; a following ADD completes normally in 1 cycle.
